debug_clock_probe: RTL and testbench

Board-level debug controller sitting between the FPGA top and the CPU core. It replaces the fixed free-running clock divider and hard-wired register-to-pin mapping with a few generalised features:
- a clock-enable generator with selectable division;
- halt, single-step and run-to-breakpoint modes;
- a snapshot multiplexer that presents any one of CHANNELS probe words (r1, pc, …) on the pin bus.

---
 rtl/debug_pkg.sv | 30 +++
 rtl/step_debounce.sv | 74 +++++++
 rtl/debug_clock_probe.sv | 175 +++++++++++++++++
 tb/tb_debug_clock_probe.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the debug clock probe: mode encodings, controller state and default widths.
package debug_pkg;

    localparam logic [1:0] MODE_HALT  = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BREAK = 2'b11;

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_BREAK = 2'b10
    } dbg_state_e;

    localparam int DEF_DIV_WIDTH   = 25;
    localparam int DEF_PROBE_WIDTH = 16;
    localparam int DEF_CHANNELS    = 4;

    // Mask with the n low bits set.
    function automatic logic [31:0] low_mask(input int n);
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) m[i] = 1'b1;
            else       m[i] = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/step_debounce.sv
// Step-button conditioning: two-flop synchroniser, optional counter debouncer
// (DEBUG_CLOCK_DEBOUNCE_EN) and a registered one-cycle rising-edge pulse.
module step_debounce
    import debug_pkg::*;
`ifdef DEBUG_CLOCK_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 50000
)
`endif
(
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic step
);

    logic sync1_r;
    logic sync2_r;
    logic clean_s;
    logic prev_r;
    logic step_r;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

`ifdef DEBUG_CLOCK_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             stable_r;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive samples that disagree with it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r    <= '0;
            stable_r <= 1'b0;
        end else if (sync2_r == stable_r) begin
            cnt_r    <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r    <= '0;
            stable_r <= sync2_r;
        end else begin
            cnt_r    <= cnt_r + CNT_W'(1);
        end
    end

    assign clean_s = stable_r;
`else
    assign clean_s = sync2_r;
`endif

    // prev_r resets high so a button already held at reset release is not seen as a press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_r <= 1'b1;
            step_r <= 1'b0;
        end else begin
            prev_r <= clean_s;
            step_r <= clean_s & ~prev_r;
        end
    end

    assign step = step_r;

endmodule

// File: rtl/debug_clock_probe.sv
// Debug clock controller: divided CPU enable, HALT/RUN/BREAK sequencing and probe snapshot mux.
// Defining DEBUG_CLOCK_DEBOUNCE_EN adds a counter debouncer on the step button.
module debug_clock_probe
    import debug_pkg::*;
#(
    parameter int DIV_WIDTH   = DEF_DIV_WIDTH,
    parameter int PROBE_WIDTH = DEF_PROBE_WIDTH,
    parameter int CHANNELS    = DEF_CHANNELS,
`ifdef DEBUG_CLOCK_DEBOUNCE_EN
    parameter int DEBOUNCE_CYCLES = 50000,
`endif
    localparam int SEL_WIDTH  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
)
(
    input  logic                            clock,
    input  logic                            reset,
    input  logic [1:0]                      mode,
    input  logic [4:0]                      div_sel,
    input  logic                            step_btn,
    input  logic [PROBE_WIDTH-1:0]          break_value,
    input  logic [CHANNELS*PROBE_WIDTH-1:0] probes,
    input  logic [SEL_WIDTH-1:0]            probe_sel,
    output logic                            cpu_clock_en,
    output logic [PROBE_WIDTH-1:0]          pins,
    output logic                            halted,
    output logic [15:0]                     step_count
);

    dbg_state_e                      state_r;
    dbg_state_e                      state_nx_s;
    logic [DIV_WIDTH-1:0]            div_cnt_r;
    logic [DIV_WIDTH-1:0]            div_mask_s;
    logic                            tick_s;
    logic                            bp_hit_s;
    logic                            step_evt_s;
    logic                            pulse_nx_s;
    logic [CHANNELS*PROBE_WIDTH-1:0] snap_r;
    logic [PROBE_WIDTH-1:0]          sel_word_s;

`ifdef DEBUG_CLOCK_DEBOUNCE_EN
    step_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step (
        .clock (clock),
        .reset (reset),
        .btn   (step_btn),
        .step  (step_evt_s)
    );
`else
    step_debounce u_step (
        .clock (clock),
        .reset (reset),
        .btn   (step_btn),
        .step  (step_evt_s)
    );
`endif

    // Free-running enable divider.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_WIDTH'(1);
        end
    end

    // Tick when the selected low divider bits are all zero; div_sel clamps at DIV_WIDTH.
    always_comb begin
        div_mask_s = '0;
        if (int'(div_sel) > DIV_WIDTH) div_mask_s = DIV_WIDTH'(low_mask(DIV_WIDTH));
        else                           div_mask_s = DIV_WIDTH'(low_mask(int'(div_sel)));
        tick_s   = ((div_cnt_r & div_mask_s) == '0);
        bp_hit_s = (probes[PROBE_WIDTH-1:0] == break_value);
    end

    // Next state and pulse decision; the current state governs the cycle a mode change arrives.
    always_comb begin
        state_nx_s = state_r;
        pulse_nx_s = 1'b0;
        case (state_r)
            ST_HALT: begin
                case (mode)
                    MODE_RUN: begin
                        state_nx_s = ST_RUN;
                        pulse_nx_s = 1'b0;
                    end
                    MODE_BREAK: begin
                        state_nx_s = ST_RUN;
                        pulse_nx_s = step_evt_s;
                    end
                    MODE_HALT, MODE_STEP: begin
                        state_nx_s = ST_HALT;
                        pulse_nx_s = step_evt_s;
                    end
                    default: begin
                        state_nx_s = ST_HALT;
                        pulse_nx_s = 1'b0;
                    end
                endcase
            end
            ST_RUN: begin
                if (mode == MODE_RUN) begin
                    state_nx_s = ST_RUN;
                    pulse_nx_s = tick_s;
                end else if (mode == MODE_BREAK) begin
                    if (tick_s && bp_hit_s) begin
                        state_nx_s = ST_BREAK;
                        pulse_nx_s = step_evt_s;
                    end else begin
                        state_nx_s = ST_RUN;
                        pulse_nx_s = tick_s | step_evt_s;
                    end
                end else begin
                    state_nx_s = ST_HALT;
                    pulse_nx_s = tick_s | step_evt_s;
                end
            end
            ST_BREAK: begin
                if (mode == MODE_BREAK) state_nx_s = ST_BREAK;
                else                    state_nx_s = ST_HALT;
                pulse_nx_s = step_evt_s && (mode != MODE_RUN);
            end
            default: begin
                state_nx_s = ST_HALT;
                pulse_nx_s = 1'b0;
            end
        endcase
    end

    // Controller state with registered pulse, halted flag and pulse counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_HALT;
            cpu_clock_en <= 1'b0;
            halted       <= 1'b1;
            step_count   <= 16'd0;
        end else begin
            state_r      <= state_nx_s;
            cpu_clock_en <= pulse_nx_s;
            halted       <= (state_r != ST_RUN);
            if (pulse_nx_s) step_count <= step_count + 16'd1;
            else            step_count <= step_count;
        end
    end

    // Capture every channel the cycle after a pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snap_r <= '0;
        end else if (cpu_clock_en) begin
            snap_r <= probes;
        end else begin
            snap_r <= snap_r;
        end
    end

    // Channel select; out-of-range selects read as zero.
    always_comb begin
        sel_word_s = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (int'(probe_sel) == k) sel_word_s = snap_r[k*PROBE_WIDTH +: PROBE_WIDTH];
            else                      sel_word_s = sel_word_s;
        end
    end

    // Registered pin bus.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pins <= '0;
        end else begin
            pins <= sel_word_s;
        end
    end

endmodule

// File: tb/tb_debug_clock_probe.sv
// Scoreboard bench for debug_clock_probe (default build, debounce off, DIV_WIDTH shortened to 6).
module tb_debug_clock_probe;

    localparam int DW = 6;
    localparam int PW = 16;
    localparam int CH = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [1:0]      mode = 2'b00;
    logic [4:0]      div_sel = 5'd0;
    logic            step_btn = 1'b0;
    logic [PW-1:0]   break_value = 16'h0000;
    logic [CH*PW-1:0] probes = '0;
    logic [1:0]      probe_sel = 2'd0;
    logic            cpu_clock_en;
    logic [PW-1:0]   pins;
    logic            halted;
    logic [15:0]     step_count;

    typedef struct {
        int          cyc;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc;
    int          n_total = 0;
    int          n_bad = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic        mon_en = 1'b0;
    int          c0;
    int          c1;

    debug_clock_probe #(
        .DIV_WIDTH   (DW),
        .PROBE_WIDTH (PW),
        .CHANNELS    (CH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mode         (mode),
        .div_sel      (div_sel),
        .step_btn     (step_btn),
        .break_value  (break_value),
        .probes       (probes),
        .probe_sel    (probe_sel),
        .cpu_clock_en (cpu_clock_en),
        .pins         (pins),
        .halted       (halted),
        .step_count   (step_count)
    );

    always #5 clock = ~clock;

    // Rising edges since reset release; equals the divider value seen in the following cycle.
    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input int at);
        exp_t e;
        exp_cnt  = exp_cnt + 16'd1;
        e.cyc    = at;
        e.cnt    = exp_cnt;
        sb_q.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    // Pulse scoreboard: every cycle either matches the queue head or shows no pulse.
    always @(negedge clock) begin
        if (mon_en) begin
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                check_val("pulse_missed", cyc, sb_q[0].cyc);
                sb_q.delete(0);
            end
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                check_val("pulse", {31'd0, cpu_clock_en}, 32'd1);
                check_val("step_count", {16'd0, step_count}, {16'd0, sb_q[0].cnt});
                sb_q.delete(0);
            end else begin
                check_val("no_pulse", {31'd0, cpu_clock_en}, 32'd0);
            end
        end
    end

    // Run mode at a given div_sel for n divider pulses, then return to halt.
    task automatic run_div(input int sel, input int n);
        int period;
        int e;
        int last;
        period  = 1 << ((sel > DW) ? DW : sel);
        mode    = 2'b01;
        div_sel = sel[4:0];
        e = cyc + 1;
        while (e % period != 0) e++;
        for (int i = 0; i < n; i++) expect_pulse(e + 1 + i * period);
        last = e + 1 + (n - 1) * period;
        wait_cyc(e + 1);
        check_val("halted_run", {31'd0, halted}, 32'd0);
        wait_cyc(last);
        mode = 2'b00;
        if (last % period == 0) expect_pulse(last + 1);
        wait_cyc(last + 4);
        check_val("halted_stop", {31'd0, halted}, 32'd1);
        check_val("sb_empty", sb_q.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check_val("rst_en", {31'd0, cpu_clock_en}, 32'd0);
        check_val("rst_pins", {16'd0, pins}, 32'd0);
        check_val("rst_halted", {31'd0, halted}, 32'd1);
        check_val("rst_count", {16'd0, step_count}, 32'd0);
        @(negedge clock);
        reset  = 1'b1;
        mon_en = 1'b1;

        run_div(0, 8);
        run_div(3, 3);
        run_div(25, 2);

        // Single step with snapshot and pin-select checks.
        probes    = {16'h3333, 16'hBEEF, 16'h1111, 16'h0000};
        probe_sel = 2'd2;
        mode      = 2'b10;
        c0        = cyc;
        step_btn  = 1'b1;
        expect_pulse(c0 + 4);
        wait_cyc(c0 + 5);
        check_val("pins_before", {16'd0, pins}, 32'd0);
        wait_cyc(c0 + 6);
        check_val("pins_ch2", {16'd0, pins}, 32'h0000BEEF);
        probe_sel = 2'd3;
        wait_cyc(c0 + 7);
        check_val("pins_ch3", {16'd0, pins}, 32'h00003333);
        wait_cyc(c0 + 100);
        step_btn = 1'b0;
        wait_cyc(c0 + 110);
        check_val("step_halted", {31'd0, halted}, 32'd1);
        check_val("sb_empty", sb_q.size(), 32'd0);

        // Run-to-break with a step press overlapping the divider ticks.
        break_value   = 16'h0042;
        div_sel       = 5'd0;
        c0            = cyc;
        probes[15:0]  = 16'h0040;
        mode          = 2'b11;
        step_btn      = 1'b1;
        for (int i = 2; i <= 9; i++) expect_pulse(c0 + i);
        wait_cyc(c0 + 8);
        probes[15:0] = 16'h0041;
        wait_cyc(c0 + 9);
        check_val("halted_rtb", {31'd0, halted}, 32'd0);
        probes[15:0] = 16'h0042;
        wait_cyc(c0 + 11);
        check_val("halted_break", {31'd0, halted}, 32'd1);
        wait_cyc(c0 + 20);
        step_btn = 1'b0;
        wait_cyc(c0 + 30);
        c1       = cyc;
        step_btn = 1'b1;
        expect_pulse(c1 + 4);
        wait_cyc(c1 + 10);
        step_btn     = 1'b0;
        probes[15:0] = 16'h0010;
        wait_cyc(c1 + 16);
        check_val("break_held", {31'd0, halted}, 32'd1);
        check_val("sb_empty", sb_q.size(), 32'd0);
        mode = 2'b00;
        wait_cyc(c1 + 20);

        // Asynchronous reset while running.
        mode    = 2'b01;
        div_sel = 5'd0;
        c0      = cyc;
        expect_pulse(c0 + 2);
        expect_pulse(c0 + 3);
        expect_pulse(c0 + 4);
        wait_cyc(c0 + 4);
        #2;
        mon_en = 1'b0;
        check_val("pre_rst_en", {31'd0, cpu_clock_en}, 32'd1);
        check_val("pre_rst_pins", {16'd0, pins}, 32'h00003333);
        reset = 1'b0;
        #1;
        check_val("midrst_en", {31'd0, cpu_clock_en}, 32'd0);
        check_val("midrst_pins", {16'd0, pins}, 32'd0);
        check_val("midrst_count", {16'd0, step_count}, 32'd0);
        check_val("midrst_halted", {31'd0, halted}, 32'd1);
        check_val("sb_empty", sb_q.size(), 32'd0);
        exp_cnt = 16'd0;
        @(negedge clock);
        @(negedge clock);
        reset  = 1'b1;
        mon_en = 1'b1;
        #1;
        check_val("post_rst_halted", {31'd0, halted}, 32'd1);
        expect_pulse(2);
        wait_cyc(2);
        mode = 2'b00;
        expect_pulse(3);
        wait_cyc(8);
        check_val("final_halted", {31'd0, halted}, 32'd1);
        check_val("sb_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
